// File: rtl/alu_pkg.sv
// Shared constants for the ALU and its sequencer: opcodes, FSM states, instruction layout.
package alu_pkg;

    localparam int DATA_W  = 8;
    localparam int REG_AW  = 2;
    localparam int INSTR_W = 1 + 3 + REG_AW + DATA_W;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_SLL = 3'b010;
    localparam logic [2:0] OP_SRL = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_EQL = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_EXEC = 2'd2;
    localparam logic [1:0] ST_WB   = 2'd3;

    // li | op | rd | rs1 | rs2 | unused ; imm overlays the low DATA_W bits
    localparam int LI_BIT  = INSTR_W - 1;
    localparam int OP_LSB  = INSTR_W - 4;
    localparam int RD_LSB  = DATA_W;
    localparam int RS1_LSB = DATA_W - REG_AW;
    localparam int RS2_LSB = DATA_W - 2 * REG_AW;

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction handshake, ALU drive/return and debug read port of the sequencer.
interface alu_sequencer_if #(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int REG_AW = alu_pkg::REG_AW
);
    localparam int INSTR_W = 1 + 3 + REG_AW + DATA_W;

    logic                in_valid;
    logic                in_ready;
    logic [INSTR_W-1:0]  in_instr;
    logic [DATA_W-1:0]   alu_a;
    logic [DATA_W-1:0]   alu_b;
    logic [2:0]          alu_op;
    logic [DATA_W-1:0]   alu_result;
    logic                done;
    logic [DATA_W-1:0]   result;
    logic [REG_AW-1:0]   dbg_addr;
    logic [DATA_W-1:0]   dbg_data;

    modport slave (
        input  in_valid, in_instr, alu_result, dbg_addr,
        output in_ready, alu_a, alu_b, alu_op, done, result, dbg_data
    );

    modport master (
        output in_valid, in_instr, alu_result, dbg_addr,
        input  in_ready, alu_a, alu_b, alu_op, done, result, dbg_data
    );
endinterface

// File: rtl/alu_regfile.sv
// 2^REG_AW x DATA_W register file, r0 hardwired to zero; combinational reads, one sync write.
// Write lands on the clock edge; synchronous active-high reset clears every entry.
module alu_regfile #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 2
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] i_ra_addr,
    input  logic [REG_AW-1:0] i_rb_addr,
    input  logic [REG_AW-1:0] i_dbg_addr,
    output logic [DATA_W-1:0] o_ra_dat,
    output logic [DATA_W-1:0] o_rb_dat,
    output logic [DATA_W-1:0] o_dbg_dat,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_dat
);
    localparam int NREG = 1 << REG_AW;

    logic [DATA_W-1:0] r_mem [NREG];

    assign o_ra_dat  = (i_ra_addr  == '0) ? '0 : r_mem[i_ra_addr];
    assign o_rb_dat  = (i_rb_addr  == '0) ? '0 : r_mem[i_rb_addr];
    assign o_dbg_dat = (i_dbg_addr == '0) ? '0 : r_mem[i_dbg_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_wr_addr != '0)) begin
            r_mem[i_wr_addr] <= i_wr_dat;
        end
    end
endmodule

// File: rtl/alu_sequencer.sv
// One-at-a-time micro-sequencer feeding an external ALU: done 4 cycles after accept (LI: 2).
// in_ready only in IDLE; nothing is buffered, so upstream holds in_valid/in_instr until accepted.
module alu_sequencer #(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int REG_AW = alu_pkg::REG_AW
)(
    input  logic          clk,
    input  logic          rst,
    alu_sequencer_if.slave bus
);
    import alu_pkg::*;

    logic [1:0]        r_state;
    logic [2:0]        r_op;
    logic [REG_AW-1:0] r_rd;
    logic [REG_AW-1:0] r_rs1;
    logic [REG_AW-1:0] r_rs2;
    logic [DATA_W-1:0] r_wb_data;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [2:0]        r_alu_op;
    logic [DATA_W-1:0] r_result;
    logic              r_done;

    logic [DATA_W-1:0] w_rs1_dat;
    logic [DATA_W-1:0] w_rs2_dat;
    logic              w_accept;
    logic              w_we;

    assign bus.in_ready = (r_state == ST_IDLE);
    assign w_accept     = bus.in_valid && (r_state == ST_IDLE);
    assign w_we         = (r_state == ST_WB);

    assign bus.alu_a  = r_alu_a;
    assign bus.alu_b  = r_alu_b;
    assign bus.alu_op = r_alu_op;
    assign bus.done   = r_done;
    assign bus.result = r_result;

    alu_regfile #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .i_ra_addr  (r_rs1),
        .i_rb_addr  (r_rs2),
        .i_dbg_addr (bus.dbg_addr),
        .o_ra_dat   (w_rs1_dat),
        .o_rb_dat   (w_rs2_dat),
        .o_dbg_dat  (bus.dbg_data),
        .i_we       (w_we),
        .i_wr_addr  (r_rd),
        .i_wr_dat   (r_wb_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_op      <= '0;
            r_rd      <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_wb_data <= '0;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_op  <= '0;
            r_result  <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op  <= bus.in_instr[OP_LSB +: 3];
                        r_rd  <= bus.in_instr[RD_LSB +: REG_AW];
                        r_rs1 <= bus.in_instr[RS1_LSB +: REG_AW];
                        r_rs2 <= bus.in_instr[RS2_LSB +: REG_AW];
                        if (bus.in_instr[LI_BIT]) begin
                            r_wb_data <= bus.in_instr[DATA_W-1:0];
                            r_state   <= ST_WB;
                        end else begin
                            r_state   <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    r_alu_a  <= w_rs1_dat;
                    r_alu_b  <= w_rs2_dat;
                    r_alu_op <= r_op;
                    r_state  <= ST_EXEC;
                end
                ST_EXEC: begin
                    r_wb_data <= bus.alu_result;
                    r_state   <= ST_WB;
                end
                ST_WB: begin
                    // register file write happens on this same edge via w_we
                    r_result <= r_wb_data;
                    r_done   <= 1'b1;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed vector table, hand-written multi-cycle sequences, random run.
module tb_alu_sequencer;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic [7:0] m_rf [4];

    always #5 clk = ~clk;

    alu_sequencer_if bus ();

    alu_sequencer u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [7:0] alu_f(logic [7:0] a, logic [7:0] b, logic [2:0] op);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_SLL:  return a << b[2:0];
            OP_SRL:  return a >> b[2:0];
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            default: return (a == b) ? 8'h01 : 8'h00;
        endcase
    endfunction

    // stand-in for the neighbouring ALU
    always_comb bus.alu_result = alu_f(bus.alu_a, bus.alu_b, bus.alu_op);

    function automatic logic [13:0] mk(logic [2:0] op, logic [1:0] rd, logic [1:0] rs1, logic [1:0] rs2);
        return {1'b0, op, rd, rs1, rs2, 4'b0000};
    endfunction

    function automatic logic [13:0] mkli(logic [1:0] rd, logic [7:0] imm);
        return {1'b1, 3'b000, rd, imm};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rf(input string tag);
        for (int i = 0; i < 4; i++) begin
            bus.dbg_addr = 2'(i);
            #1;
            check($sformatf("%s_rf%0d", tag, i), {24'h0, bus.dbg_data}, {24'h0, m_rf[i]});
        end
    endtask

    // Issue one instruction, wait for its retire, compare against the model (or table values).
    task automatic run_instr(input logic [13:0] instr, input bit use_tbl,
                             input logic [7:0] t_res, input int t_lat, input string tag);
        logic       li;
        logic [1:0] rd;
        logic [7:0] ea, eb, eres;
        logic [7:0] sa, sb;
        logic [2:0] sop;
        int         elat, lat, n;
        bit         busy_ok;
        li = instr[13];
        rd = instr[9:8];
        ea = m_rf[instr[7:6]];
        eb = m_rf[instr[5:4]];
        eres = li ? instr[7:0] : alu_f(ea, eb, instr[12:10]);
        elat = li ? 2 : 4;
        if (use_tbl) begin
            eres = t_res;
            elat = t_lat;
        end
        n = 0;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, {31'h0, bus.in_ready}, 32'h1);
        bus.in_instr = instr;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.in_instr = $urandom_range(0, 16383);
        lat = 1;
        busy_ok = 1'b1;
        sa = '0; sb = '0; sop = '0;
        while (!bus.done && lat < 12) begin
            if (bus.in_ready) busy_ok = 1'b0;
            if (lat == 2) begin
                sa = bus.alu_a; sb = bus.alu_b; sop = bus.alu_op;
            end
            tick();
            lat++;
        end
        check({tag, "_done"}, {31'h0, bus.done}, 32'h1);
        check({tag, "_latency"}, lat, elat);
        check({tag, "_result"}, {24'h0, bus.result}, {24'h0, eres});
        check({tag, "_busy_not_ready"}, {31'h0, busy_ok}, 32'h1);
        if (!li) begin
            check({tag, "_exec_a"}, {24'h0, sa}, {24'h0, ea});
            check({tag, "_exec_b"}, {24'h0, sb}, {24'h0, eb});
            check({tag, "_exec_op"}, {29'h0, sop}, {29'h0, instr[12:10]});
        end
        bus.dbg_addr = rd;
        #1;
        check({tag, "_dbg_rd"}, {24'h0, bus.dbg_data}, (rd == 2'd0) ? 32'h0 : {24'h0, eres});
        if (rd != 2'd0) m_rf[rd] = eres;
    endtask

    typedef struct {
        logic [13:0] instr;
        logic [7:0]  exp_res;
        int          exp_lat;
    } vec_t;

    vec_t tbl [18];
    logic [13:0] bb [3];
    logic [7:0]  bb_exp [3];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  idx, retired, accepted;
        bit  acc, no_done;

        tbl[0]  = '{mkli(2'd1, 8'h2A),          8'h2A, 2};
        tbl[1]  = '{mkli(2'd1, 8'hF0),          8'hF0, 2};
        tbl[2]  = '{mkli(2'd2, 8'h20),          8'h20, 2};
        tbl[3]  = '{mk(OP_ADD, 2'd3, 2'd1, 2'd2), 8'h10, 4};
        tbl[4]  = '{mkli(2'd1, 8'h05),          8'h05, 2};
        tbl[5]  = '{mkli(2'd2, 8'h03),          8'h03, 2};
        tbl[6]  = '{mk(OP_SUB, 2'd3, 2'd2, 2'd1), 8'hFE, 4};
        tbl[7]  = '{mkli(2'd1, 8'h07),          8'h07, 2};
        tbl[8]  = '{mkli(2'd2, 8'h07),          8'h07, 2};
        tbl[9]  = '{mk(OP_EQL, 2'd3, 2'd1, 2'd2), 8'h01, 4};
        tbl[10] = '{mkli(2'd2, 8'h08),          8'h08, 2};
        tbl[11] = '{mk(OP_EQL, 2'd3, 2'd1, 2'd2), 8'h00, 4};
        tbl[12] = '{mkli(2'd1, 8'h81),          8'h81, 2};
        tbl[13] = '{mkli(2'd2, 8'h01),          8'h01, 2};
        tbl[14] = '{mk(OP_SLL, 2'd3, 2'd1, 2'd2), 8'h02, 4};
        tbl[15] = '{mkli(2'd1, 8'h01),          8'h01, 2};
        tbl[16] = '{mkli(2'd2, 8'h02),          8'h02, 2};
        tbl[17] = '{mk(OP_ADD, 2'd0, 2'd1, 2'd2), 8'h03, 4};

        for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
        bus.in_valid = 1'b0;
        bus.in_instr = '0;
        bus.dbg_addr = '0;

        // reset state
        repeat (3) tick();
        rst = 1'b0;
        check("rst_in_ready", {31'h0, bus.in_ready}, 32'h1);
        check("rst_done", {31'h0, bus.done}, 32'h0);
        check("rst_result", {24'h0, bus.result}, 32'h0);
        check("rst_alu_a", {24'h0, bus.alu_a}, 32'h0);
        check("rst_alu_op", {29'h0, bus.alu_op}, 32'h0);
        check_rf("rst");

        for (int i = 0; i < 18; i++) begin
            run_instr(tbl[i].instr, 1'b1, tbl[i].exp_res, tbl[i].exp_lat, $sformatf("vec%0d", i));
        end
        check_rf("vec_end");

        tick();
        check("done_pulse_width", {31'h0, bus.done}, 32'h0);

        // in_valid held high with a stream of instructions
        bb[0] = mkli(2'd1, 8'h33);            bb_exp[0] = 8'h33;
        bb[1] = mk(OP_ADD, 2'd2, 2'd1, 2'd1); bb_exp[1] = 8'h66;
        bb[2] = mkli(2'd3, 8'h11);            bb_exp[2] = 8'h11;
        idx = 0; retired = 0; accepted = 0;
        bus.in_instr = bb[0];
        bus.in_valid = 1'b1;
        for (int cyc = 0; cyc < 40 && retired < 3; cyc++) begin
            if (bus.done) begin
                check($sformatf("b2b_result%0d", retired), {24'h0, bus.result}, {24'h0, bb_exp[retired]});
                if (retired < 2) begin
                    check($sformatf("b2b_accept_in_done%0d", retired), {31'h0, bus.in_ready}, 32'h1);
                end
                retired++;
            end
            acc = bus.in_ready && bus.in_valid;
            tick();
            if (acc) begin
                accepted++;
                idx++;
                if (idx < 3) bus.in_instr = bb[idx];
                else bus.in_valid = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        check("b2b_retired", retired, 3);
        check("b2b_accepted", accepted, 3);
        m_rf[1] = 8'h33; m_rf[2] = 8'h66; m_rf[3] = 8'h11;
        check_rf("b2b");

        // reset in the middle of an ALU instruction
        run_instr(mkli(2'd1, 8'h05), 1'b0, 8'h00, 0, "pre_rst1");
        run_instr(mkli(2'd2, 8'h09), 1'b0, 8'h00, 0, "pre_rst2");
        bus.in_instr = mk(OP_ADD, 2'd2, 2'd1, 2'd2);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        check("mid_exec_alu_a", {24'h0, bus.alu_a}, 32'h05);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
        check("mid_rst_in_ready", {31'h0, bus.in_ready}, 32'h1);
        check("mid_rst_done", {31'h0, bus.done}, 32'h0);
        check("mid_rst_result", {24'h0, bus.result}, 32'h0);
        check("mid_rst_alu_b", {24'h0, bus.alu_b}, 32'h0);
        no_done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (bus.done) no_done = 1'b0;
            tick();
        end
        check("mid_rst_no_done", {31'h0, no_done}, 32'h1);
        check_rf("mid_rst");

        // random instructions against the model
        for (int i = 0; i < 40; i++) begin
            run_instr(14'($urandom_range(0, 16383)), 1'b0, 8'h00, 0, $sformatf("rnd%0d", i));
            if ($urandom_range(0, 3) == 0) tick();
        end
        check_rf("rnd_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle micro-sequencer that sits directly upstream of the 8-bit ALU.
- Accepts one instruction at a time over a valid/ready handshake and reads operands from an internal 4 x 8-bit register file.
- Drives the ALU operand and opcode inputs, captures the ALU result, writes it back, and reports it with a one-cycle done pulse.
- The ALU is instantiated beside this block by the parent, not inside it.

Parameters:
- DATA_W, 8, datapath/register width; must match ALU width.
- REG_AW, 2, register address width (2^REG_AW registers).
- INSTR_W, 14, instruction width; derived, not to be overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction valid.
- in_ready  out  1  sequencer can accept an instruction.
- in_instr  in  14  instruction word (format below).
- alu_a  out  8  ALU operand a.
- alu_b  out  8  ALU operand b.
- alu_op  out  3  ALU op_code.
- alu_result  in  8  ALU alu_out; combinational from alu_a, alu_b, alu_op.
- done  out  1  one-cycle pulse: instruction retired.
- result  out  8  value retired by the instruction; held until the next retire.
- dbg_addr  in  2  debug register-file read address.
- dbg_data  out  8  combinational read of rf[dbg_addr].

Behaviour:
- Instruction format:
  - [13] li: load-immediate flag.
  - [12:10] op: ALU code 000 ADD, 001 SUB, 010 SLL, 011 SRL, 100 AND, 101 OR, 110 XOR, 111 EQL.
  - [9:8] rd.
  - [7:6] rs1.
  - [5:4] rs2.
  - When li=1, [7:0] is imm, and op/rs1/rs2 are ignored.
- Register file:
  - r0 always reads 0; writes to r0 are discarded.
  - r1..r3 reset to 0.
- FSM states: IDLE, READ, EXEC, WB. Reset state is IDLE.
- in_ready = (state==IDLE). It is combinational and is high in the first cycle after reset deasserts.
- IDLE:
  - On in_valid & in_ready, latch in_instr.
  - If li=1: wb_data <= imm, go to WB.
  - Otherwise go to READ.
  - With no handshake, stay in IDLE.
- READ:
  - alu_a <= rf[rs1]; alu_b <= rf[rs2]; alu_op <= op.
  - Go to EXEC.
- EXEC: ALU inputs are stable; wb_data <= alu_result; go to WB.
- WB:
  - If rd != 0, rf[rd] <= wb_data.
  - result <= wb_data; done <= 1.
  - Go to IDLE.
- done is registered and deasserts the following cycle unless another retire occurs.
- Latency, counted from the handshake cycle:
  - ALU instruction: done is high 4 cycles later.
  - LI: done is high 2 cycles later.
  - In the cycle done is high, the register file already holds the new value.
- Back-to-back instructions:
  - A new instruction may be accepted in the same cycle done is high.
  - A dependent read sees the updated register; no forwarding is needed.
- in_valid while in_ready=0 is ignored. No instruction is buffered, and upstream must hold it.
- Write to r0: result and done are still reported with the computed value; the register file is unchanged.
- Arithmetic: widths are fixed at 8 bits. The carry out of ADD is not observed, and SUB wraps modulo 256.
- rst asserted in any state, including mid-instruction:
  - Next state is IDLE.
  - rf, alu_a, alu_b, alu_op, wb_data and result are cleared to 0.
  - done = 0, and no partial write occurs.
- alu_a, alu_b and alu_op hold their last values outside READ.

Decomposition:
- Package alu_pkg holds:
  - ALU opcode constants: ADD..EQL, 3-bit.
  - The FSM state enum.
  - Instruction field bit positions and DATA_W.
- The ALU is updated to import the same opcode constants.
- Natural sub-module: alu_regfile, a 4x8 register file with 2 combinational read ports plus a debug read port, 1 synchronous write port, r0 hardwired to 0, and synchronous reset.

Test Plan:
- Reset, then LI r1=0x2A → done is high 2 cycles after the handshake; result=0x2A; dbg r1=0x2A; in_ready=0 during WB.
- LI r1=0xF0, LI r2=0x20, ADD r3=r1+r2 → result=0x10 (wraps); done is high 4 cycles after the handshake; during EXEC, alu_a=0xF0, alu_b=0x20, alu_op=000.
- SUB r3=r2-r1 with r1=0x05, r2=0x03 → 0xFE. EQL with r1=r2=0x07 → 0x01; with r1≠r2 → 0x00. SLL of 0x81 → 0x02.
- ADD rd=r0, with operands 0x01 and 0x02 → done with result=0x03; dbg r0 reads 0x00.
- Hold in_valid high with distinct instructions throughout → exactly one accept per IDLE cycle. The second instruction is accepted in the done cycle and reads the updated rd.
- Assert rst during EXEC of ADD r2 → no done; state is IDLE; rf all 0; in_ready=1 the cycle after rst deasserts.
